avalon_burst_ram_slave: RTL and testbench
=========================================

Name: avalon_burst_ram_slave

Overview:
Avalon-MM responder (slave) terminating one output port of the Avalon crossbar. It provides a word-addressed, byte-enabled on-chip RAM and supports incrementing bursts of up to 255 beats.
- No readdatavalid signal. Read data for each accepted read beat is presented on the cycle after acceptance, which matches the crossbar's registered read-data return path.
- Waitrequest is the only flow-control signal.

Parameters:
ADDR_WIDTH, 10, local word-address bits; memory depth = 2^ADDR_WIDTH 32-bit words
WAIT_STATES, 0, waitrequest cycles inserted before the first beat of every burst (0..15)

Ports:
i_Clk  in  1  clock
i_Rst  in  1  asynchronous active-high reset
i_AV_Addr  in  30  word address; bits above ADDR_WIDTH ignored
i_AV_ByteEn  in  4  byte lane enables for writes
i_AV_Read  in  1  read request
o_AV_ReadData  out  32  read data, valid the cycle after an accepted read beat
i_AV_Write  in  1  write request
i_AV_WriteData  in  32  write data
o_AV_WaitRequest  out  1  stall; a beat is accepted when (Read|Write) && !WaitRequest
i_AV_BurstCount  in  8  beats in burst, sampled on first beat only; 0 treated as 1

Behaviour:
- Reset (async, i_Rst=1): state=IDLE; beat counter=0; wait counter=0; o_AV_ReadData=0; o_AV_WaitRequest=1 while in reset. Memory contents are not cleared.
- FSM states: IDLE, WAIT, RBURST, WBURST.
- IDLE:
  - With Read or Write asserted, capture Addr, BurstCount (0->1) and direction.
  - WAIT_STATES>0: go to WAIT, WaitRequest=1.
  - WAIT_STATES=0: first beat accepted this cycle (WaitRequest=0 combinationally), then go to R/WBURST, or stay in IDLE if burst=1.
  - Read and Write both asserted: Write wins.
  - With no request, WaitRequest=1.
- WAIT: count WAIT_STATES cycles with WaitRequest=1, then enter R/WBURST with the first beat still pending.
- RBURST / WBURST:
  - WaitRequest=0 only while the matching command is asserted.
  - The opposite command sees WaitRequest=1 and is ignored.
  - Both deasserted: pause, no beat consumed.
  - Each accepted beat uses the internal address, then increments it modulo 2^ADDR_WIDTH (wrap-around). Mid-burst i_AV_Addr is ignored.
  - Remaining beats decrement per beat; after the last beat, return to IDLE.
  - The next burst may start on the cycle after returning to IDLE.
- Writes: each byte lane i is written where ByteEn[i]=1. ByteEn=0 completes the beat with no change.
- Reads:
  - o_AV_ReadData is registered and holds the memory word of the accepted beat for the following cycle.
  - It holds its last value until the next accepted read.
  - Read-during-write to the same address cannot occur (single port, one beat per cycle).
- Latency: first beat accepted WAIT_STATES cycles after the request appears; read data 1 cycle after acceptance; throughput 1 beat/cycle inside a burst.
- Reset mid-burst: burst aborted immediately; FSM returns to IDLE; no further writes occur.

Optional Feature:
Macro AVALON_SLAVE_PERF_CNT_EN.
- Defined: adds outputs o_RdBeats (16) and o_WrBeats (16).
  - Each counts accepted read/write beats.
  - Saturating at 16'hFFFF.
  - Reset to 0.
  - Synchronous clear input i_CntClr (1) clears both; clear wins over a simultaneous increment.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package avalon_pkg:
  - AV_ADDR_W=30, AV_DATA_W=32, AV_BE_W=4, AV_BURST_W=8
  - state encoding typedef (IDLE/WAIT/RBURST/WBURST)
  - function normalising burstcount 0->1
- Sub-module av_be_ram: single-port RAM with 4 byte-lane write enables and registered read. It is instantiated once and holds all storage.
- The FSM, counters and waitrequest logic live in the top module.

Test Plan:
1. WAIT_STATES=0, single write Addr=5, Data=32'hDEADBEEF, ByteEn=4'hF, Burst=1; then read Addr=5 -> no wait on either beat; ReadData=32'hDEADBEEF exactly 1 cycle after read acceptance.
2. Write 32'h11223344 to Addr=7, then write ByteEn=4'b0101, Data=32'hAABBCCDD to Addr=7; read Addr=7 -> ReadData=32'h11BB33DD.
3. WAIT_STATES=3, write burst Addr=1022, Burst=4, data 1..4 (ADDR_WIDTH=10) -> 3 waitrequest cycles then 4 beats; read back shows words 1022,1023,0,1 = 1,2,3,4 (wrap-around).
4. Read burst Burst=0 -> treated as 1 beat; FSM returns to IDLE; a following write is accepted on the next cycle.
5. Write burst Burst=8 with Write deasserted for 2 cycles mid-burst and Read asserted during the gap -> Read sees WaitRequest=1; burst resumes and completes 8 beats at consecutive addresses.
6. Assert i_Rst after beat 2 of a 6-beat write burst -> WaitRequest=1 and ReadData=0 immediately; only beats 0-1 written; after release, a new burst starts from IDLE. With AVALON_SLAVE_PERF_CNT_EN defined, o_WrBeats=0 after the reset.

Source files
------------

// File: rtl/avalon_burst_ram_slave_pkg.sv
// Shared Avalon-MM widths, FSM state encoding and burstcount normalisation
// for the burst RAM responder.
package avalon_pkg;

    localparam int AV_ADDR_W  = 30;
    localparam int AV_DATA_W  = 32;
    localparam int AV_BE_W    = 4;
    localparam int AV_BURST_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RBURST = 2'd2,
        ST_WBURST = 2'd3
    } av_state_t;

    // A burstcount of zero is treated as a single beat.
    function automatic logic [AV_BURST_W-1:0] norm_burst(input logic [AV_BURST_W-1:0] bc);
        return (bc == '0) ? AV_BURST_W'(1) : bc;
    endfunction

endpackage

// File: rtl/av_be_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port
// that holds its value until the next read.
module av_be_ram
    import avalon_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_We,
    input  logic                  i_Re,
    input  logic [AV_BE_W-1:0]    i_ByteEn,
    input  logic [ADDR_WIDTH-1:0] i_Addr,
    input  logic [AV_DATA_W-1:0]  i_WrData,
    output logic [AV_DATA_W-1:0]  o_RdData
);

    logic [AV_BE_W-1:0][7:0] mem [2**ADDR_WIDTH];
    logic [AV_BE_W-1:0][7:0] wr_lanes;

    assign wr_lanes = i_WrData;

    // Storage is never reset; only the read register is.
    always_ff @(posedge i_Clk) begin
        if (i_We) begin
            for (int i = 0; i < AV_BE_W; i++) begin
                if (i_ByteEn[i]) mem[i_Addr][i] <= wr_lanes[i];
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)     o_RdData <= '0;
        else if (i_Re) o_RdData <= mem[i_Addr];
    end

endmodule

// File: rtl/avalon_burst_ram_slave.sv
// Avalon-MM burst RAM responder: waitrequest-only flow control, read data one
// cycle after acceptance. Optional beat counters under AVALON_SLAVE_PERF_CNT_EN.
module avalon_burst_ram_slave
    import avalon_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [AV_ADDR_W-1:0]  i_AV_Addr,
    input  logic [AV_BE_W-1:0]    i_AV_ByteEn,
    input  logic                  i_AV_Read,
    output logic [AV_DATA_W-1:0]  o_AV_ReadData,
    input  logic                  i_AV_Write,
    input  logic [AV_DATA_W-1:0]  i_AV_WriteData,
    output logic                  o_AV_WaitRequest,
    input  logic [AV_BURST_W-1:0] i_AV_BurstCount
`ifdef AVALON_SLAVE_PERF_CNT_EN
    ,
    input  logic                  i_CntClr,
    output logic [15:0]           o_RdBeats,
    output logic [15:0]           o_WrBeats
`endif
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    av_state_t               state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [AV_BURST_W-1:0]   beats_q;
    logic [3:0]              wait_q;
    logic                    dir_wr_q;

    logic                    rd_acc, wr_acc;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [AV_BURST_W-1:0]   first_bc;
    av_state_t               burst_st;
    logic                    unused_addr_hi;

    assign unused_addr_hi = ^i_AV_Addr[AV_ADDR_W-1:ADDR_WIDTH];
    assign first_bc       = norm_burst(i_AV_BurstCount);
    assign burst_st       = i_AV_Write ? ST_WBURST : ST_RBURST;

    // IDLE uses the bus address; inside a burst the internal counter drives the RAM.
    always_comb begin
        rd_acc   = 1'b0;
        wr_acc   = 1'b0;
        ram_addr = addr_q;
        unique case (state)
            ST_IDLE: begin
                ram_addr = i_AV_Addr[ADDR_WIDTH-1:0];
                if (WAIT_STATES == 0) begin
                    wr_acc = i_AV_Write;
                    rd_acc = i_AV_Read & ~i_AV_Write;
                end
            end
            ST_RBURST: rd_acc = i_AV_Read;
            ST_WBURST: wr_acc = i_AV_Write;
            default: ;
        endcase
        if (i_Rst) begin
            rd_acc = 1'b0;
            wr_acc = 1'b0;
        end
    end

    assign o_AV_WaitRequest = ~(rd_acc | wr_acc);

    // The request cycle in IDLE counts as the first wait cycle, so WAIT itself
    // lasts WAIT_STATES-1 cycles and the first beat lands WAIT_STATES cycles later.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            beats_q  <= '0;
            wait_q   <= '0;
            dir_wr_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (i_AV_Read | i_AV_Write) begin
                        dir_wr_q <= i_AV_Write;
                        if (WAIT_STATES == 0) begin
                            addr_q  <= ram_addr + ADDR_ONE;
                            beats_q <= first_bc - AV_BURST_W'(1);
                            if (first_bc != AV_BURST_W'(1)) state <= burst_st;
                        end else begin
                            addr_q  <= ram_addr;
                            beats_q <= first_bc;
                            wait_q  <= 4'(WAIT_STATES - 2);
                            state   <= (WAIT_STATES == 1) ? burst_st : ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_q == '0) state <= dir_wr_q ? ST_WBURST : ST_RBURST;
                    else              wait_q <= wait_q - 4'd1;
                end
                default: begin
                    if (rd_acc | wr_acc) begin
                        addr_q  <= addr_q + ADDR_ONE;
                        beats_q <= beats_q - AV_BURST_W'(1);
                        if (beats_q == AV_BURST_W'(1)) state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    av_be_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_We     (wr_acc),
        .i_Re     (rd_acc),
        .i_ByteEn (i_AV_ByteEn),
        .i_Addr   (ram_addr),
        .i_WrData (i_AV_WriteData),
        .o_RdData (o_AV_ReadData)
    );

`ifdef AVALON_SLAVE_PERF_CNT_EN
    // Saturating beat counters; clear has priority over a same-cycle beat.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_RdBeats <= '0;
            o_WrBeats <= '0;
        end else if (i_CntClr) begin
            o_RdBeats <= '0;
            o_WrBeats <= '0;
        end else begin
            if (rd_acc && o_RdBeats != 16'hFFFF) o_RdBeats <= o_RdBeats + 16'd1;
            if (wr_acc && o_WrBeats != 16'hFFFF) o_WrBeats <= o_WrBeats + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_avalon_burst_ram_slave.sv
// Directed bench: one responder with no wait states and one with three,
// sharing a single master-side stimulus bus.
module tb_avalon_burst_ram_slave;

    logic        clk, rst;
    logic        r, w;
    logic [29:0] a;
    logic [7:0]  bc;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        wreq0, wreq1, wreq;
    logic [31:0] rd0, rd1, rdata;
    logic        sel;
    int          tests, fails;
    int          wt;
`ifdef AVALON_SLAVE_PERF_CNT_EN
    logic        clr;
    logic [15:0] rdb0, wrb0, rdb1, wrb1;
`endif

    assign wreq  = sel ? wreq1 : wreq0;
    assign rdata = sel ? rd1   : rd0;

    avalon_burst_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .i_Clk(clk), .i_Rst(rst), .i_AV_Addr(a), .i_AV_ByteEn(be),
        .i_AV_Read(r), .o_AV_ReadData(rd0), .i_AV_Write(w),
        .i_AV_WriteData(wd), .o_AV_WaitRequest(wreq0), .i_AV_BurstCount(bc)
`ifdef AVALON_SLAVE_PERF_CNT_EN
        , .i_CntClr(clr), .o_RdBeats(rdb0), .o_WrBeats(wrb0)
`endif
    );

    avalon_burst_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut1 (
        .i_Clk(clk), .i_Rst(rst), .i_AV_Addr(a), .i_AV_ByteEn(be),
        .i_AV_Read(r), .o_AV_ReadData(rd1), .i_AV_Write(w),
        .i_AV_WriteData(wd), .o_AV_WaitRequest(wreq1), .i_AV_BurstCount(bc)
`ifdef AVALON_SLAVE_PERF_CNT_EN
        , .i_CntClr(clr), .o_RdBeats(rdb1), .o_WrBeats(wrb1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one beat at the falling edge, wait out waitrequest, return just
    // after the accepting rising edge with the number of stalled cycles.
    task automatic beat(input logic rd_i, input logic wr_i, input logic [29:0] ad,
                        input logic [7:0] bcnt, input logic [31:0] d,
                        input logic [3:0] ben, output int waits);
        waits = 0;
        @(negedge clk);
        r = rd_i; w = wr_i; a = ad; bc = bcnt; wd = d; be = ben;
        #1;
        while (wreq && waits < 40) begin
            @(negedge clk); #1;
            waits++;
        end
        if (waits >= 40) chk("beat_timeout", 32'(waits), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        r = 1'b0; w = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0; sel = 1'b0;
        r = 0; w = 0; a = '0; bc = 8'd1; wd = '0; be = 4'hF;
`ifdef AVALON_SLAVE_PERF_CNT_EN
        clr = 1'b0;
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_waitreq", 32'(wreq), 32'd1);
        chk("reset_rdata", rdata, 32'h0);
        rst = 1'b0;

        // 1: single write then single read, no stalls
        beat(0, 1, 30'd5, 8'd1, 32'hDEADBEEF, 4'hF, wt);
        chk("t1_wr_wait", 32'(wt), 32'd0);
        beat(1, 0, 30'd5, 8'd1, 32'h0, 4'hF, wt);
        chk("t1_rd_wait", 32'(wt), 32'd0);
        chk("t1_rdata", rdata, 32'hDEADBEEF);

        // 2: byte-lane merge
        beat(0, 1, 30'd7, 8'd1, 32'h11223344, 4'hF, wt);
        beat(0, 1, 30'd7, 8'd1, 32'hAABBCCDD, 4'b0101, wt);
        beat(1, 0, 30'd7, 8'd1, 32'h0, 4'hF, wt);
        chk("t2_rdata", rdata, 32'h11BB33DD);
        idle();
        #1 chk("t2_hold", rdata, 32'h11BB33DD);
        chk("idle_waitreq", 32'(wreq), 32'd1);

        // 4: burstcount 0 is one beat; next write accepted immediately
        beat(1, 0, 30'd5, 8'd0, 32'h0, 4'hF, wt);
        chk("t4_rd_wait", 32'(wt), 32'd0);
        chk("t4_rdata", rdata, 32'hDEADBEEF);
        beat(0, 1, 30'd9, 8'd1, 32'h00000099, 4'hF, wt);
        chk("t4_wr_wait", 32'(wt), 32'd0);
        beat(1, 0, 30'd9, 8'd1, 32'h0, 4'hF, wt);
        chk("t4_rdback", rdata, 32'h00000099);

        // 5: 8-beat write burst with a 2-cycle gap while Read is asserted
        for (int i = 0; i < 3; i++) begin
            beat(0, 1, 30'd100, 8'd8, 32'(100 + i), 4'hF, wt);
            chk("t5_wr_wait_pre", 32'(wt), 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            w = 1'b0; r = 1'b1; a = 30'd200;
            #1 chk("t5_gap_waitreq", 32'(wreq), 32'd1);
        end
        for (int i = 3; i < 8; i++) begin
            beat(0, 1, 30'd500, 8'd3, 32'(100 + i), 4'hF, wt);
            chk("t5_wr_wait_post", 32'(wt), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            beat(1, 0, 30'd100, 8'd8, 32'h0, 4'hF, wt);
            chk("t5_rd_wait", 32'(wt), 32'd0);
            chk("t5_rdata", rdata, 32'(100 + i));
        end
        idle();
        #1 chk("t5_hold", rdata, 32'd107);

        // 6: reset after two beats of a 6-beat write burst
        for (int i = 0; i < 6; i++) beat(0, 1, 30'd300, 8'd6, 32'h0, 4'hF, wt);
        for (int i = 0; i < 2; i++) beat(0, 1, 30'd300, 8'd6, 32'hA0 + 32'(i), 4'hF, wt);
        @(negedge clk);
        rst = 1'b1; w = 1'b1; wd = 32'hA2;
        #1;
        chk("t6_rst_waitreq", 32'(wreq), 32'd1);
        chk("t6_rst_rdata", rdata, 32'h0);
`ifdef AVALON_SLAVE_PERF_CNT_EN
        chk("t6_wrbeats", 32'(wrb0), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0; w = 1'b0;
        for (int i = 0; i < 6; i++) begin
            beat(1, 0, 30'd300, 8'd6, 32'h0, 4'hF, wt);
            chk("t6_rd_wait", 32'(wt), 32'd0);
            chk("t6_rdata", rdata, (i < 2) ? 32'hA0 + 32'(i) : 32'h0);
        end
        idle();
`ifdef AVALON_SLAVE_PERF_CNT_EN
        #1 chk("t6_rdbeats", 32'(rdb0), 32'd6);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        chk("t6_clr", 32'(rdb0), 32'd0);
`endif

        // 3: three wait states, wrapping write/read burst on the second responder
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat(0, 1, 30'd1022, 8'd4, 32'(i + 1), 4'hF, wt);
            chk("t3_wr_wait", 32'(wt), (i == 0) ? 32'd3 : 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            beat(1, 0, 30'd1022, 8'd4, 32'h0, 4'hF, wt);
            chk("t3_rd_wait", 32'(wt), (i == 0) ? 32'd3 : 32'd0);
            chk("t3_rdata", rdata, 32'(i + 1));
        end
        idle();
        #1 chk("t3_idle_waitreq", 32'(wreq), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
